axil_ram_slave: RTL and testbench
=================================

// Module: axil_ram_slave
// PURPOSE
//   AXI4-Lite responder (slave) fronting a single-port word RAM; target of the boot FSM's AW/W
//   writes (RAM copy / UART update) and, once the CPU is released, of CPU loads/stores.
//   AW and W channels are accepted independently. Each write returns one B response; reads are
//   served on AR/R with 1-cycle latency.
// PARAMETERS
//   BASE_ADDR   32'h0001_0000  byte address of word 0
//   MEM_WORDS   256            RAM depth in 32-bit words (power of 2, >=2)
// PORTS
//   clk        in   1   clock; all state updates on rising edge
//   resetn     in   1   reset, synchronous, active-low
//   s_awaddr   in   32  write address (byte)
//   s_awvalid  in   1   write address valid
//   s_awready  out  1   write address accepted this cycle when high with s_awvalid
//   s_wdata    in   32  write data
//   s_wstrb    in   4   byte enables, bit i -> wdata[8i+7:8i]
//   s_wvalid   in   1   write data valid
//   s_wready   out  1   write data ready
//   s_bresp    out  2   write response: 2'b00 OKAY, 2'b10 SLVERR
//   s_bvalid   out  1   write response valid
//   s_bready   in   1   write response ready
//   s_araddr   in   32  read address (byte)
//   s_arvalid  in   1   read address valid
//   s_arready  out  1   read address ready
//   s_rdata    out  32  read data
//   s_rresp    out  2   read response: 2'b00 OKAY, 2'b10 SLVERR
//   s_rvalid   out  1   read data valid
//   s_rready   in   1   read data ready
// BEHAVIOUR
//   Reset: bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, AW/W holding regs empty. RAM contents NOT
//     reset. Reset mid-transaction discards held AW/W and pending B/R; a half-received write never commits.
//   Decode: in range iff BASE_ADDR <= addr < BASE_ADDR+4*MEM_WORDS (32-bit unsigned compare,
//     no wrap). Index = (addr-BASE_ADDR)>>2; addr[1:0] ignored.
//   Write path: one AW holding reg, one W holding reg.
//     s_awready = !aw_full && !s_bvalid ; s_wready = !w_full && !s_bvalid (combinational).
//     AW and W may arrive in either order or same cycle; handshake sets the respective full flag.
//   Write states: W_COLLECT -> (aw_full && w_full, or handshakes completing them) -> W_RESP.
//     Commit edge = edge when the second of AW/W is held: in-range -> RAM bytes with wstrb=1 updated,
//     bresp=OKAY; out-of-range -> no RAM change, bresp=SLVERR. bvalid rises the cycle after both held
//     (min latency: AW+W same cycle N -> bvalid at N+1). wstrb=0 -> OKAY, RAM unchanged.
//   W_RESP: bvalid/bresp stable until s_bready; on bvalid&&bready clear bvalid and both full flags,
//     return W_COLLECT; new AW/W accepted no earlier than the following cycle. Max one outstanding write.
//   Read path: s_arready = !s_rvalid. On AR handshake at edge N: rdata = RAM[idx] (or 32'h0 with
//     rresp=SLVERR if out-of-range), rvalid=1 from N+1. rdata/rresp stable while rvalid && !rready.
//     On rvalid&&rready rvalid clears; next AR accepted the cycle after. Max one outstanding read.
//   Simultaneous read + write commit to same word on same edge: read returns OLD data (read-before-write).
//   Read and write paths fully independent; no ordering between them beyond the above.
//   Inputs are not required to be valid-stable by this block, but AXI rules are assumed of masters:
//     once valid is high it stays high with stable payload until handshake.
// TESTING
//   1 AW+W same cycle, addr 0x0001_0000, data 0x1300_0013, strb F, bready=1 -> bvalid at +1, bresp 00;
//     AR same addr -> rvalid next cycle, rdata 0x1300_0013, rresp 00.
//   2 W two cycles before AW (addr 0x0001_0004, data 0xA5A5_A5A5) -> wready low after W held, bvalid
//     one cycle after AW handshake; readback 0xA5A5_A5A5.
//   3 Byte strobes: word=0xFFFF_FFFF, then write 0x1122_3344 strb 4'b0101 -> readback 0xFF22_FF44.
//   4 Out-of-range write 0x0000_0000 and read 0x0001_0400 (MEM_WORDS=256) -> bresp 10 / rresp 10,
//     rdata 0, RAM unchanged.
//   5 Backpressure: bready=0 for 5 cycles -> bvalid/bresp stable, awready=wready=0 throughout;
//     rready=0 -> rdata stable, arready=0.
//   6 Reset asserted with AW held, W not -> after reset bvalid=0, subsequent read of that word unchanged;
//     AR and write commit same word same edge -> old data returned, new data on next read.

Source files
------------

// File: rtl/axil_ram_slave.sv
// AXI4-Lite responder in front of a single-port 32-bit word RAM.
// AW and W are captured independently into one holding register each.
// A write commits on the edge where the second of the pair is held.
// Reads complete in one cycle and use read-before-write ordering.
module axil_ram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready
);

  localparam int unsigned IW    = $clog2(MEM_WORDS);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(MEM_WORDS * 4);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    W_COLLECT = 1'b0,
    W_RESP    = 1'b1
  } wstate_e;

  // Unsigned 33-bit compare so that the upper bound cannot wrap.
  function automatic logic addr_in_range(input logic [31:0] addr);
    return ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < LIMIT);
  endfunction

  // The word index ignores the two byte-offset bits.
  function automatic logic [IW-1:0] addr_index(input logic [31:0] addr);
    return IW'((addr - BASE_ADDR) >> 5'd2);
  endfunction

  logic [31:0] mem [MEM_WORDS];

  wstate_e     wstate_q, wstate_d;
  logic        aw_full_q, w_full_q;
  logic [31:0] awaddr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  bresp_q;
  logic        bvalid_s;

  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic        aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, commit_s, cm_ok_s;
  logic [31:0] cm_addr_s, cm_data_s;
  logic [3:0]  cm_strb_s;

  assign s_awready = !aw_full_q && !bvalid_s;
  assign s_wready  = !w_full_q && !bvalid_s;
  assign s_arready = !rvalid_q;

  assign aw_hs_s = s_awvalid && s_awready;
  assign w_hs_s  = s_wvalid && s_wready;
  assign b_hs_s  = bvalid_s && s_bready;
  assign ar_hs_s = s_arvalid && s_arready;

  // The payload comes from the holding register if it is already full.
  // Otherwise it comes straight from the bus during this cycle's handshake.
  assign commit_s  = (wstate_q == W_COLLECT) && (aw_full_q || aw_hs_s) && (w_full_q || w_hs_s);
  assign cm_addr_s = aw_full_q ? awaddr_q : s_awaddr;
  assign cm_data_s = w_full_q ? wdata_q : s_wdata;
  assign cm_strb_s = w_full_q ? wstrb_q : s_wstrb;
  assign cm_ok_s   = addr_in_range(cm_addr_s);

  assign s_bvalid = bvalid_s;
  assign s_bresp  = bresp_q;
  assign s_rvalid = rvalid_q;
  assign s_rdata  = rdata_q;
  assign s_rresp  = rresp_q;

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wstate_q <= W_COLLECT;
    end else begin
      wstate_q <= wstate_d;
    end
  end

  // Write FSM next state: enter W_RESP on commit, leave it on the B handshake.
  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_COLLECT: begin
        if (commit_s) wstate_d = W_RESP;
        else          wstate_d = W_COLLECT;
      end
      W_RESP: begin
        if (s_bready) wstate_d = W_COLLECT;
        else          wstate_d = W_RESP;
      end
      default: wstate_d = W_COLLECT;
    endcase
  end

  // Write FSM outputs: the response is valid for the whole of W_RESP.
  always_comb begin
    bvalid_s = 1'b0;
    case (wstate_q)
      W_RESP:    bvalid_s = 1'b1;
      W_COLLECT: bvalid_s = 1'b0;
      default:   bvalid_s = 1'b0;
    endcase
  end

  // AW/W holding registers and the latched write response.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      awaddr_q  <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
      wstrb_q   <= 4'h0;
      bresp_q   <= RESP_OKAY;
    end else if (b_hs_s) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
    end else begin
      if (aw_hs_s) begin
        aw_full_q <= 1'b1;
        awaddr_q  <= s_awaddr;
      end
      if (w_hs_s) begin
        w_full_q <= 1'b1;
        wdata_q  <= s_wdata;
        wstrb_q  <= s_wstrb;
      end
      if (commit_s) begin
        bresp_q <= cm_ok_s ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // RAM byte-lane write on commit. RAM contents are not reset.
  always_ff @(posedge clk) begin
    if (resetn && commit_s && cm_ok_s) begin
      for (int i = 0; i < 4; i++) begin
        if (cm_strb_s[i]) begin
          mem[addr_index(cm_addr_s)][8*i +: 8] <= cm_data_s[8*i +: 8];
        end
      end
    end
  end

  // Read path: capture the word on AR handshake and hold it until R is accepted.
  // Because this is a non-blocking RAM read, a same-edge write is not yet visible.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0000_0000;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs_s) begin
      rvalid_q <= 1'b1;
      if (addr_in_range(s_araddr)) begin
        rdata_q <= mem[addr_index(s_araddr)];
        rresp_q <= RESP_OKAY;
      end else begin
        rdata_q <= 32'h0000_0000;
        rresp_q <= RESP_SLVERR;
      end
    end else if (rvalid_q && s_rready) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_ram_slave.sv
// Self-checking bench for axil_ram_slave.
// Directed cases come first, followed by randomized reads and writes.
// All traffic is checked against an array model of the RAM.
module tb_axil_ram_slave;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          WORDS = 256;

  logic        clk;
  logic        resetn;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;

  axil_ram_slave #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS)) dut (
    .clk(clk), .resetn(resetn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] ref_mem [WORDS];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit ref_hit(input logic [31:0] a);
    longint ua = longint'(a);
    return (ua >= longint'(BASE)) && (ua < longint'(BASE) + longint'(WORDS * 4));
  endfunction

  function automatic int ref_idx(input logic [31:0] a);
    return int'((a - BASE) / 32'd4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run a full write transaction.
  // AW and W are presented after independent lags; bready follows b_hold cycles after bvalid.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_lag, input int w_lag, input int b_hold, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, b_done = 0, aw_hs, w_hs, b_hs;
    int cyc = 0, both_cyc = -1, bv_cyc = -1;
    logic [1:0] exp_resp = ref_hit(addr) ? 2'b00 : 2'b10;
    resp = 2'b11;
    check_eq("b_idle", 32'(s_bvalid), 32'd0);
    while (!b_done && cyc < 200) begin
      if (s_bvalid) begin
        if (bv_cyc < 0) begin
          bv_cyc = cyc;
          resp = s_bresp;
          check_eq("b_latency", 32'(cyc - both_cyc), 32'd1);
        end else begin
          check_eq("bresp_stable", 32'(s_bresp), 32'(resp));
        end
      end
      if (aw_done) check_eq("awready_held", 32'(s_awready), 32'd0);
      if (w_done)  check_eq("wready_held", 32'(s_wready), 32'd0);
      s_awvalid = !aw_done && (cyc >= aw_lag);
      s_awaddr  = addr;
      s_wvalid  = !w_done && (cyc >= w_lag);
      s_wdata   = data;
      s_wstrb   = strb;
      s_bready  = (bv_cyc >= 0) && (cyc - bv_cyc >= b_hold);
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      b_hs  = s_bvalid && s_bready;
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      if (aw_done && w_done && both_cyc < 0) begin
        both_cyc = cyc;
        if (ref_hit(addr)) begin
          for (int i = 0; i < 4; i++)
            if (strb[i]) ref_mem[ref_idx(addr)][8*i +: 8] = data[8*i +: 8];
        end
      end
      if (b_hs) b_done = 1;
      cyc++;
    end
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    if (!b_done) check_eq("wr_timeout", 32'd0, 32'd1);
    check_eq("bresp", 32'(resp), 32'(exp_resp));
  endtask

  // Run a full read transaction, with rready following r_hold cycles after rvalid.
  task automatic axi_read(input logic [31:0] addr, input int ar_lag, input int r_hold,
                          output logic [31:0] data, output logic [1:0] resp);
    bit ar_done = 0, r_done = 0, ar_hs, r_hs;
    int cyc = 0, ar_cyc = -1, rv_cyc = -1;
    logic [31:0] exp_d = ref_hit(addr) ? ref_mem[ref_idx(addr)] : 32'h0000_0000;
    logic [1:0]  exp_r = ref_hit(addr) ? 2'b00 : 2'b10;
    data = 32'h0;
    resp = 2'b11;
    check_eq("r_idle", 32'(s_rvalid), 32'd0);
    while (!r_done && cyc < 200) begin
      if (s_rvalid) begin
        if (rv_cyc < 0) begin
          rv_cyc = cyc;
          data = s_rdata;
          resp = s_rresp;
          check_eq("r_latency", 32'(cyc - ar_cyc), 32'd1);
        end else begin
          check_eq("rdata_stable", s_rdata, data);
          check_eq("rresp_stable", 32'(s_rresp), 32'(resp));
        end
        check_eq("arready_busy", 32'(s_arready), 32'd0);
      end
      s_arvalid = !ar_done && (cyc >= ar_lag);
      s_araddr  = addr;
      s_rready  = (rv_cyc >= 0) && (cyc - rv_cyc >= r_hold);
      ar_hs = s_arvalid && s_arready;
      r_hs  = s_rvalid && s_rready;
      tick();
      if (ar_hs) begin
        ar_done = 1;
        ar_cyc = cyc;
      end
      if (r_hs) r_done = 1;
      cyc++;
    end
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    if (!r_done) check_eq("rd_timeout", 32'd0, 32'd1);
    check_eq("rdata", data, exp_d);
    check_eq("rresp", 32'(resp), 32'(exp_r));
  endtask

  task automatic check_idle_after_reset();
    check_eq("rst_bvalid", 32'(s_bvalid), 32'd0);
    check_eq("rst_rvalid", 32'(s_rvalid), 32'd0);
    check_eq("rst_bresp", 32'(s_bresp), 32'd0);
    check_eq("rst_rresp", 32'(s_rresp), 32'd0);
    check_eq("rst_rdata", s_rdata, 32'd0);
    check_eq("rst_awready", 32'(s_awready), 32'd1);
    check_eq("rst_wready", 32'(s_wready), 32'd1);
    check_eq("rst_arready", 32'(s_arready), 32'd1);
  endtask

  logic [31:0] rd;
  logic [1:0]  rs, bs;
  logic [31:0] old_w, new_w, a;

  initial begin
    resetn = 1'b0;
    s_awaddr = 32'h0; s_awvalid = 1'b0; s_wdata = 32'h0; s_wstrb = 4'h0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = 32'h0; s_arvalid = 1'b0; s_rready = 1'b0;
    repeat (3) tick();
    check_idle_after_reset();
    resetn = 1'b1;
    tick();

    // 1: AW and W in the same cycle, then read back.
    axi_write(BASE, 32'h1300_0013, 4'hF, 0, 0, 0, bs);
    check_eq("t1_bresp", 32'(bs), 32'd0);
    axi_read(BASE, 0, 0, rd, rs);
    check_eq("t1_rdata", rd, 32'h1300_0013);

    // 2: W arrives two cycles before AW.
    axi_write(BASE + 32'd4, 32'hA5A5_A5A5, 4'hF, 2, 0, 0, bs);
    axi_read(BASE + 32'd4, 0, 0, rd, rs);
    check_eq("t2_rdata", rd, 32'hA5A5_A5A5);

    // 3: byte strobes, including an all-zero strobe.
    axi_write(BASE + 32'd8, 32'hFFFF_FFFF, 4'hF, 0, 1, 0, bs);
    axi_write(BASE + 32'd8, 32'h1122_3344, 4'b0101, 1, 0, 0, bs);
    axi_read(BASE + 32'd8, 0, 0, rd, rs);
    check_eq("t3_rdata", rd, 32'hFF22_FF44);
    axi_write(BASE + 32'd8, 32'h0000_0000, 4'b0000, 0, 0, 0, bs);
    check_eq("t3_strb0_bresp", 32'(bs), 32'd0);
    axi_read(BASE + 32'd8, 0, 0, rd, rs);
    check_eq("t3_strb0_rdata", rd, 32'hFF22_FF44);

    // 4: out-of-range write and read.
    axi_write(32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, bs);
    check_eq("t4_bresp", 32'(bs), 32'd2);
    axi_read(BASE + 32'h400, 0, 0, rd, rs);
    check_eq("t4_rresp", 32'(rs), 32'd2);
    check_eq("t4_rdata", rd, 32'd0);
    axi_read(BASE, 0, 0, rd, rs);
    check_eq("t4_unchanged", rd, 32'h1300_0013);

    // 5: back-pressure on B and R.
    axi_write(BASE + 32'd12, 32'h5555_AAAA, 4'hF, 0, 0, 5, bs);
    axi_read(BASE + 32'd12, 0, 5, rd, rs);
    check_eq("t5_rdata", rd, 32'h5555_AAAA);

    // Fill the whole RAM so that every word has a known value.
    for (int i = 0; i < WORDS; i++)
      axi_write(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0, 0, bs);

    // 6a: reset while AW is held and W is not. The write must be discarded.
    old_w = ref_mem[2];
    s_awaddr = BASE + 32'd8; s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    check_eq("t6_aw_held", 32'(s_awready), 32'd0);
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    check_idle_after_reset();
    s_wdata = 32'hDEAD_0000; s_wstrb = 4'hF; s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("t6_no_commit", 32'(s_bvalid), 32'd0);
      tick();
    end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    axi_read(BASE + 32'd8, 0, 0, rd, rs);
    check_eq("t6_word_kept", rd, old_w);

    // 6b: a read and a write commit to the same word on the same edge.
    old_w = ref_mem[3];
    new_w = old_w ^ 32'h0F0F_F0F0;
    s_awaddr = BASE + 32'd12; s_awvalid = 1'b1;
    s_wdata = new_w; s_wstrb = 4'hF; s_wvalid = 1'b1;
    s_araddr = BASE + 32'd12; s_arvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    check_eq("t6_bvalid", 32'(s_bvalid), 32'd1);
    check_eq("t6_rvalid", 32'(s_rvalid), 32'd1);
    check_eq("t6_old_data", s_rdata, old_w);
    s_bready = 1'b1; s_rready = 1'b1;
    tick();
    s_bready = 1'b0; s_rready = 1'b0;
    ref_mem[3] = new_w;
    axi_read(BASE + 32'd12, 0, 0, rd, rs);
    check_eq("t6_new_data", rd, new_w);

    // Randomized mix of reads and writes, including out-of-range addresses and boundaries.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        8:       a = BASE + 32'h400 + 32'(4 * $urandom_range(0, 15));
        9: begin
          case ($urandom_range(0, 3))
            0:       a = BASE - 32'd4;
            1:       a = 32'h0000_0000;
            2:       a = BASE + 32'h3FC;
            default: a = 32'hFFFF_FFFC;
          endcase
        end
        default: a = BASE + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 1) == 0)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), bs);
      else
        axi_read(a, $urandom_range(0, 3), $urandom_range(0, 3), rd, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
